// File: rtl/sub_bytes_folded.sv
// Area-folded AES SubBytes/InvSubBytes: LANES bytes per cycle through shared S-box lanes.
// Define SUB_BYTES_INV_EN to build the inv_sbox lanes and honour the inv input.

package sub_bytes_pkg;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

endpackage

module sbox
    import sub_bytes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    output logic [7:0] q
);
    logic [7:0] i;
    logic [7:0] s;

    assign i = ginv(a);
    assign s = i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 8'h00;
        else     q <= s;
    end
endmodule

module inv_sbox
    import sub_bytes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    output logic [7:0] q
);
    logic [7:0] s;

    assign s = ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 8'h00;
        else     q <= s;
    end
endmodule

module sub_bytes_folded #(
    parameter int DATA_W = 128,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    input  logic              inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dout,
    output logic              busy
);
    localparam int CHUNKS = DATA_W / (8 * LANES);
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int SW     = 8 * LANES;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] res_q;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     chunk;
    logic [SW-1:0]     fwd_q;
    logic [SW-1:0]     lane_q;
    logic [CW-1:0]     wr_idx;
    logic              accept;
    logic              wr_en;

    assign accept = in_valid && in_ready;
    assign chunk  = din_q[int'(cnt) * SW +: SW];
    assign wr_en  = (state == FEED && cnt != '0) || state == DRAIN;
    assign wr_idx = (state == DRAIN) ? LAST : cnt - 1'b1;
    assign dout   = res_q;

    for (genvar l = 0; l < LANES; l++) begin : g_fwd
        sbox u_sbox (.clk(clk), .rst(rst), .a(chunk[8*l +: 8]), .q(fwd_q[8*l +: 8]));
    end

`ifdef SUB_BYTES_INV_EN
    logic          mode;
    logic [SW-1:0] inv_q;

    for (genvar l = 0; l < LANES; l++) begin : g_inv
        inv_sbox u_inv_sbox (.clk(clk), .rst(rst), .a(chunk[8*l +: 8]), .q(inv_q[8*l +: 8]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         mode <= 1'b0;
        else if (accept) mode <= inv;
    end

    assign lane_q = mode ? inv_q : fwd_q;
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign lane_q     = fwd_q;
`endif

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = FEED;
            end
            FEED:  if (cnt == LAST) state_nx = DRAIN;
            DRAIN: state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // slot k lands one cycle after chunk k was presented to the lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            din_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                din_q <= din;
                cnt   <= '0;
            end else if (state == FEED) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            if (wr_en) res_q[int'(wr_idx) * SW +: SW] <= lane_q;
        end
    end
endmodule

// File: tb/tb_sub_bytes_folded.sv
// Scoreboard bench for sub_bytes_folded: default instance plus LANES=1/2/16 latency sweep.
// Reference S-box is built from exp/log tables over generator 3.

module tb_sub_bytes_folded;

    localparam logic [127:0] V_PT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_SB = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] din;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;
    logic         busy;

    logic         sw_valid;
    logic [127:0] sw_din;
    logic         sw_inv;
    logic         sw_out_ready;
    logic [2:0]   sw_in_ready;
    logic [2:0]   sw_out_valid;
    logic [2:0]   sw_busy;
    logic [127:0] sw_dout [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] exp_q [$];
    logic [127:0] last_dout;

    always #5 clk = ~clk;

    sub_bytes_folded u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .inv(inv), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .busy(busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int LN = (g == 0) ? 1 : (g == 1) ? 2 : 16;
        sub_bytes_folded #(.DATA_W(128), .LANES(LN)) u_sw (
            .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[g]),
            .din(sw_din), .inv(sw_inv), .out_valid(sw_out_valid[g]),
            .out_ready(sw_out_ready), .dout(sw_dout[g]), .busy(sw_busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] p);
        return {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_tables();
        logic [7:0] ex [256];
        int         lg [256];
        logic [7:0] p;
        logic [7:0] y;
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h63;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = p;
            lg[p] = i;
            p = p ^ xt(p);
        end
        for (int x = 0; x < 256; x++) begin
            y = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
            for (int k = 0; k < 8; k++)
                b[k] = y[k] ^ y[(k+4)%8] ^ y[(k+5)%8] ^ y[(k+6)%8] ^ y[(k+7)%8] ^ c[k];
            sb[x]  = b;
            isb[b] = x[7:0];
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic m);
        logic [127:0] r;
        logic         use_inv;
`ifdef SUB_BYTES_INV_EN
        use_inv = m;
`else
        use_inv = 1'b0 & m;
`endif
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = use_inv ? isb[d[8*i +: 8]] : sb[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // full transaction; inv and din are scrambled every cycle while busy
    task automatic xfer(input logic [127:0] d, input logic m, input int hold);
        int           n;
        logic [127:0] want;
        @(negedge clk);
        din      = d;
        inv      = m;
        in_valid = 1'b1;
        check("accept_ready", in_ready, 1);
        exp_q.push_back(model(d, m));
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            inv = ~inv;
            din = rnd128();
            @(negedge clk);
            n++;
        end
        check("latency", n, 5);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("dout", dout, want);
        last_dout = dout;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            din      = rnd128();
            inv      = ~inv;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check("hold_dout", dout, want);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_dout", dout, want);
    endtask

    task automatic sweep();
        int lat [3];
        for (int g = 0; g < 3; g++) lat[g] = -1;
        @(negedge clk);
        sw_din   = V_PT;
        sw_valid = 1'b1;
        check("sw_ready", sw_in_ready, 3'b111);
        @(negedge clk);
        sw_valid = 1'b0;
        sw_din   = rnd128();
        for (int n = 0; n < 40; n++) begin
            for (int g = 0; g < 3; g++) begin
                if (sw_out_valid[g] && lat[g] < 0) begin
                    lat[g] = n;
                    check($sformatf("sw_dout%0d", g), sw_dout[g], V_SB);
                end
            end
            @(negedge clk);
        end
        check("sw_lat_l1", lat[0], 17);
        check("sw_lat_l2", lat[1], 9);
        check("sw_lat_l16", lat[2], 2);
    endtask

    initial begin
        logic [127:0] d;
        build_tables();
        rst          = 1'b1;
        in_valid     = 1'b0;
        din          = '0;
        inv          = 1'b0;
        out_ready    = 1'b0;
        sw_valid     = 1'b0;
        sw_din       = '0;
        sw_inv       = 1'b0;
        sw_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dout, 0);

        xfer(V_PT, 1'b0, 0);
        check("vec_fwd", last_dout, V_SB);

        xfer(V_SB, 1'b1, 0);
`ifdef SUB_BYTES_INV_EN
        check("vec_inv", last_dout, V_PT);
`endif
        xfer({16{8'h63}}, 1'b1, 0);

        xfer(rnd128(), 1'b0, 10);

        d = rnd128();
        d[15:0] = 16'h5300;
        xfer(d, 1'b0, 0);
        check("mode_b0", last_dout[7:0], 8'h63);
        check("mode_b1", last_dout[15:8], 8'hed);

        @(negedge clk);
        din      = rnd128();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b0;
        xfer(rnd128(), 1'b0, 0);

        for (int i = 0; i < 6; i++) xfer(rnd128(), 1'($urandom_range(0, 1)), i % 3);

        sweep();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sub_bytes_folded.md
# sub_bytes_folded

Parametrised, area-folded AES SubBytes/InvSubBytes stage. It accepts one DATA_W-bit state over a valid/ready handshake and pushes LANES bytes per cycle through shared `sbox`/`inv_sbox` lanes. It reassembles the result in an output register and presents it over a second valid/ready handshake. It replaces the fully parallel 16-lane inverse substitution in the cipher datapath where area matters more than throughput.

## Interface
Parameters:
- `DATA_W`, default 128: state width in bits; must be a multiple of 8*LANES.
- `LANES`, default 4: bytes substituted per cycle; legal values are 1, 2, 4, 8, 16.
- Derived `CHUNKS` = DATA_W/(8*LANES), default 4.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high; clears all state, including the S-box lane registers.
- `in_valid`  in  1: `din`/`inv` are valid.
- `in_ready`  out  1: block is idle and can accept a state.
- `din`  in  DATA_W: input state; byte i = din[8i+7:8i].
- `inv`  in  1: selects the table. 1 = inverse S-box, 0 = forward. Sampled on acceptance.
- `out_valid`  out  1: `dout` holds a complete result.
- `out_ready`  in  1: downstream accepts `dout`.
- `dout`  out  DATA_W: substituted state; byte i = S(din byte i) or InvS(din byte i).
- `busy`  out  1: high in any state other than IDLE.

## Operation
- Internal resources: a DATA_W input register, a latched mode bit, a chunk counter (clog2(CHUNKS) bits, min 1), the result register, and LANES instances of `sbox` plus LANES instances of `inv_sbox`. Each S-box instance has 1-cycle registered latency.
- Chunk k covers bytes k*LANES … k*LANES+LANES-1, processed in ascending k order.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, latch `din` and `inv`, clear the counter, go to FEED.
  - FEED: drive chunk[counter] to the S-box lanes. Increment the counter each cycle. Go to DRAIN after chunk CHUNKS-1 is driven.
  - DRAIN: for one cycle, write the last S-box output into result slot CHUNKS-1, then go to DONE.
  - DONE: `out_valid`=1 and `dout` is held stable. On `out_ready`, go to IDLE.
- Result slot k is written on the cycle after chunk k is driven. In FEED, slot counter-1 is written concurrently with driving chunk counter.
- Lane output select uses the latched mode bit, never the live `inv` input.
- `inv` changes while busy have no effect.
- `in_valid` while busy is ignored: `in_ready`=0, nothing is latched.
- Output handshake uses no skid buffer. After the `out_ready` handshake, IDLE is entered and `in_ready` rises the next cycle. There is no same-cycle turnaround.
- `out_ready` asserted outside DONE is ignored.
- Reset mid-operation aborts the block, discards the result, and enters IDLE.
- When LANES=16 and DATA_W=128, CHUNKS=1: FEED lasts 1 cycle, followed by DRAIN, then DONE.

## Timing
- Reset values:
  - `in_ready`=1
  - `out_valid`=0
  - `busy`=0
  - `dout`=0
  - FSM = IDLE
  - counter = 0
- Acceptance edge E0. Chunk k is registered by the S-boxes at edge E(k+1). Result slot k is written at edge E(k+2).
- `out_valid` rises after edge E(CHUNKS+1): latency is CHUNKS+1 cycles (default 5). With `out_ready` held high, throughput is one state per CHUNKS+3 cycles.
- `dout` remains stable from `out_valid` rising until the handshake completes. It keeps its value in IDLE until the next result overwrites it.

## Configuration
- `SUB_BYTES_INV_EN` defined:
  - The `inv_sbox` lanes are instantiated.
  - `inv`=1 selects the inverse table.
- `SUB_BYTES_INV_EN` undefined:
  - No `inv_sbox` lanes exist.
  - `inv` is ignored and the block is forward-only.
  - Latency and handshake behaviour are identical to the defined case.

## Test plan
- Forward, default params: `din`=0x193de3bea0f4e22b9ac68d2ae9f84808, `inv`=0 -> `dout`=0xd42711aee0bf98f1b8b45de51e415230. `out_valid` rises 5 cycles after acceptance.
- Inverse round trip (macro defined): `din`=0xd42711aee0bf98f1b8b45de51e415230, `inv`=1 -> `dout`=0x193de3bea0f4e22b9ac68d2ae9f84808. Also all-0x63 input -> all-0x00 output.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE -> `dout` is stable, `in_ready`=0, and a `din` presented meanwhile is not latched. Release -> IDLE, then `in_ready`=1 on the next cycle.
- Mode latch: accept with `inv`=0, then toggle `inv` every cycle while busy -> output is the forward result. Bytes 0x00 and 0x53 map to 0x63 and 0xED.
- Reset mid-FEED: assert `rst` at E2 -> `out_valid`=0, `busy`=0, `in_ready`=1, `dout`=0 immediately. A following transfer completes correctly.
- Parameter sweep: LANES=1, 2, 16 with DATA_W=128 -> latencies of 17, 9 and 2 cycles, with results matching the first vector. Forward-only build with `inv`=1 -> forward result.
